serial_adder: RTL and testbench

SERIAL_ADDER -- requirements
Module: serial_adder

---
 rtl/serial_adder_pkg.sv | 22 ++
 rtl/serial_adder_full_adder.sv | 32 +++
 rtl/serial_adder.sv | 124 ++++++++++++
 tb/tb_serial_adder.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/serial_adder_pkg.sv
`default_nettype none
// ============================================================================
// Module      : serial_adder_pkg
// Description : Shared types and constants for the bit-serial adder:
//               FSM state encoding and the legal WIDTH range.
// Revision    : 1.0 - initial release
// ============================================================================
package serial_adder_pkg;

    // Legal operand widths for serial_adder
    localparam int c_WIDTH_MIN = 2;
    localparam int c_WIDTH_MAX = 32;

    // Controller states, explicitly encoded
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

endpackage : serial_adder_pkg
`default_nettype wire

// File: rtl/serial_adder_full_adder.sv
`default_nettype none
// ============================================================================
// Module      : full_adder
// Description : One-bit full adder built from two half-adder stages whose
//               carries are merged by an OR.
// Revision    : 1.0 - initial release
// ============================================================================
module full_adder (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);

    logic w_hs1_s;
    logic w_hs1_c;
    logic w_hs2_c;

    // First half adder: a + b
    assign w_hs1_s = a ^ b;
    assign w_hs1_c = a & b;

    // Second half adder: partial sum + carry-in
    assign s       = w_hs1_s ^ ci;
    assign w_hs2_c = w_hs1_s & ci;

    // At most one stage can generate a carry, so OR merges them
    assign co      = w_hs1_c | w_hs2_c;

endmodule : full_adder
`default_nettype wire

// File: rtl/serial_adder.sv
`default_nettype none
// ============================================================================
// Module      : serial_adder
// Description : Bit-serial adder, LSB first, one bit per clock. WIDTH bits
//               take WIDTH cycles; done pulses once with {c,s} = a + b.
//               Optional subtract mode enabled by macro SERIAL_ADDER_SUB_EN
//               (adds port sub; sub=1 computes a - b, c=1 means no borrow).
//               WIDTH must lie within c_WIDTH_MIN..c_WIDTH_MAX (2..32).
// Revision    : 1.0 - initial release
// ============================================================================
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
`ifdef SERIAL_ADDER_SUB_EN
    input  logic             sub,
`endif
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] s,
    output logic             c,
    output logic             busy,
    output logic             done
);

    localparam int c_CNT_W = $clog2(WIDTH);

    state_t             r_state;
    logic [WIDTH-1:0]   r_a;
    logic [WIDTH-1:0]   r_b;
    logic [WIDTH-1:0]   r_res;
    logic               r_carry;
    logic [c_CNT_W-1:0] r_cnt;
    logic [WIDTH-1:0]   r_s;
    logic               r_c;
    logic               r_busy;
    logic               r_done;

    logic               w_sum;
    logic               w_co;
    logic [WIDTH-1:0]   w_b_in;
    logic               w_ci_in;

    // Operand B and initial carry as loaded on start; subtract is a + ~b + 1
`ifdef SERIAL_ADDER_SUB_EN
    assign w_b_in  = sub ? ~b : b;
    assign w_ci_in = sub;
`else
    assign w_b_in  = b;
    assign w_ci_in = 1'b0;
`endif

    // Single shared bit-slice: the LSBs of the shift registers plus carry
    full_adder u_fa (
        .a  (r_a[0]),
        .b  (r_b[0]),
        .ci (r_carry),
        .s  (w_sum),
        .co (w_co)
    );

    // Controller, datapath shift registers and registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_a     <= '0;
            r_b     <= '0;
            r_res   <= '0;
            r_carry <= 1'b0;
            r_cnt   <= '0;
            r_s     <= '0;
            r_c     <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE, DONE: begin
                    if (start) begin
                        r_a     <= a;
                        r_b     <= w_b_in;
                        r_carry <= w_ci_in;
                        r_cnt   <= '0;
                        r_busy  <= 1'b1;
                        r_state <= SHIFT;
                    end else begin
                        r_state <= IDLE;
                    end
                end
                SHIFT: begin
                    r_a     <= r_a >> 1;
                    r_b     <= r_b >> 1;
                    r_carry <= w_co;
                    r_res   <= {w_sum, r_res[WIDTH-1:1]};
                    if (r_cnt == c_CNT_W'(WIDTH - 1)) begin
                        // Last bit: publish the full result, never a partial one
                        r_s     <= {w_sum, r_res[WIDTH-1:1]};
                        r_c     <= w_co;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_state <= DONE;
                    end else begin
                        r_cnt <= r_cnt + c_CNT_W'(1);
                    end
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign s    = r_s;
    assign c    = r_c;
    assign busy = r_busy;
    assign done = r_done;

endmodule : serial_adder
`default_nettype wire

// File: tb/tb_serial_adder.sv
`default_nettype none
// ============================================================================
// Module      : tb_serial_adder
// Description : Directed self-checking bench for serial_adder (WIDTH=8 and a
//               WIDTH=16 instance). Subtract vectors run when
//               SERIAL_ADDER_SUB_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_serial_adder;

    logic        clk = 1'b0;
    logic        rst;
    logic        sub;
    logic        start;
    logic [7:0]  a, b, s;
    logic        c, busy, done;

    logic        sub16;
    logic        start16;
    logic [15:0] a16, b16, s16;
    logic        c16, busy16, done16;

    int n_total = 0;
    int n_bad   = 0;

    always #5 clk = ~clk;

    serial_adder #(.WIDTH(8)) u_dut8 (
        .clk   (clk),
        .rst   (rst),
`ifdef SERIAL_ADDER_SUB_EN
        .sub   (sub),
`endif
        .start (start),
        .a     (a),
        .b     (b),
        .s     (s),
        .c     (c),
        .busy  (busy),
        .done  (done)
    );

    serial_adder #(.WIDTH(16)) u_dut16 (
        .clk   (clk),
        .rst   (rst),
`ifdef SERIAL_ADDER_SUB_EN
        .sub   (sub16),
`endif
        .start (start16),
        .a     (a16),
        .b     (b16),
        .s     (s16),
        .c     (c16),
        .busy  (busy16),
        .done  (done16)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    // Count negedges until done (bounded); also count cycles with busy high
    task automatic wait_done8(output int lat, output int bcnt);
        lat  = 0;
        bcnt = 0;
        while (done !== 1'b1 && lat < 64) begin
            if (busy === 1'b1) bcnt++;
            @(negedge clk);
            lat++;
        end
    endtask

    // One complete operation on the 8-bit DUT, called at a negedge
    task automatic run8(input string tag, input logic [7:0] ta, input logic [7:0] tb,
                        input logic tsub, input logic [7:0] es, input logic ec);
        int lat, bcnt;
        a = ta; b = tb; sub = tsub; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done8(lat, bcnt);
        check({tag, "_lat"},  lat,  8);
        check({tag, "_busy"}, bcnt, 8);
        check({tag, "_s"},    s,    es);
        check({tag, "_c"},    c,    ec);
        @(negedge clk);
        check({tag, "_done_pulse"}, {busy, done}, 2'b00);
    endtask

    initial begin
        int lat, bcnt, gap, ndone;
        rst = 1'b1; start = 1'b0; sub = 1'b0; a = '0; b = '0;
        start16 = 1'b0; sub16 = 1'b0; a16 = '0; b16 = '0;
        repeat (2) @(negedge clk);
        check("rst_state", {s, c, busy, done}, 11'h0);
        rst = 1'b0;

        // Plain additions, start issued on the first edge after reset
        run8("zero",  8'h00, 8'h00, 1'b0, 8'h00, 1'b0);
        run8("ovf",   8'hFF, 8'h01, 1'b0, 8'h00, 1'b1);
        run8("alt",   8'hA5, 8'h5A, 1'b0, 8'hFF, 1'b0);
        run8("max",   8'hFF, 8'hFF, 1'b0, 8'hFE, 1'b1);
        run8("mix",   8'h3C, 8'h0F, 1'b0, 8'h4B, 1'b0);

        // Back-to-back with start held high
        a = 8'h10; b = 8'h20; start = 1'b1;
        @(negedge clk);
        wait_done8(lat, bcnt);
        check("b2b1_lat", lat, 8);
        check("b2b1_s",   s,   8'h30);
        check("b2b1_c",   c,   1'b0);
        a = 8'h80; b = 8'h80;
        @(negedge clk);
        check("b2b_busy_again", busy, 1'b1);
        wait_done8(lat, bcnt);
        gap = lat + 1;
        check("b2b_gap", gap, 9);
        check("b2b2_s",  s,   8'h00);
        check("b2b2_c",  c,   1'b1);
        start = 1'b0;
        @(negedge clk);

        // start and operand change during SHIFT are ignored
        a = 8'h33; b = 8'h44; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        a = 8'hFF; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done8(lat, bcnt);
        check("midop_lat", lat + 4, 8);
        check("midop_s",   s, 8'h77);
        check("midop_c",   c, 1'b0);
        @(negedge clk);

        // Asynchronous reset in the middle of SHIFT
        a = 8'h12; b = 8'h34; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        rst = 1'b1;
        #1;
        check("abort_out", {s, c, busy, done}, 11'h0);
        @(negedge clk);
        rst = 1'b0;
        ndone = 0;
        repeat (12) begin
            @(negedge clk);
            if (done === 1'b1) ndone++;
        end
        check("abort_no_done", ndone, 0);
        run8("after_rst", 8'h12, 8'h34, 1'b0, 8'h46, 1'b0);

`ifdef SERIAL_ADDER_SUB_EN
        run8("sub_neg", 8'h05, 8'h07, 1'b1, 8'hFE, 1'b0);
        run8("sub_pos", 8'h07, 8'h05, 1'b1, 8'h02, 1'b1);
`endif

        // 16-bit instance
        a16 = 16'hFFFF; b16 = 16'h0001; start16 = 1'b1;
        @(negedge clk);
        start16 = 1'b0;
        lat = 0; bcnt = 0;
        while (done16 !== 1'b1 && lat < 64) begin
            if (busy16 === 1'b1) bcnt++;
            @(negedge clk);
            lat++;
        end
        check("w16_lat",  lat,  16);
        check("w16_busy", bcnt, 16);
        check("w16_s",    s16,  16'h0000);
        check("w16_c",    c16,  1'b1);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule : tb_serial_adder
`default_nettype wire
